fifo_rd_ctrl: RTL

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_param_pkg.sv | 21 ++
 rtl/fifo_rd_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/fifo_param_pkg.sv
// Shared defaults and types for the FIFO read-side controller.
// Build option: FIFO_RD_ERR_CNT_EN adds the saturating underflow counter.
package fifo_param_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);

    typedef logic [ADDR_W_DEF:0]   ptr_t;
    typedef logic [DATA_W_DEF-1:0] word_t;

    // 8-bit increment that holds at all-ones instead of rolling over.
    function automatic logic [7:0] sat_inc8(input logic [7:0] val);
        if (val == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = val + 8'd1;
        end
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a synchronous-read FIFO memory: pointer, pop handshake, flags.
// Build option: FIFO_RD_ERR_CNT_EN adds output err_cnt (saturating underflow count).
module fifo_rd_ctrl
    import fifo_param_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int AE_THRESH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     rd_en,
    input  logic                     flush,
    input  logic [$clog2(DEPTH):0]   wr_ptr,
    output logic [$clog2(DEPTH):0]   rd_ptr,
    output logic                     mem_rd_en,
    output logic [$clog2(DEPTH)-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     fifo_empty,
    output logic                     fifo_almost_empty,
    output logic                     fifo_rd_err,
`ifdef FIFO_RD_ERR_CNT_EN
    output logic [7:0]               err_cnt,
`endif
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] PTR_ZERO = (ADDR_W+1)'(0);
    localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W+1)'(AE_THRESH);

    logic [ADDR_W:0] r_rd_ptr;
    logic            r_rd_valid;
    logic            r_empty;
    logic            r_almost_empty;
    logic            r_rd_err;
    logic [ADDR_W:0] r_fill_level;

    logic [ADDR_W:0] w_fill;
    logic [ADDR_W:0] w_fill_nxt;
    logic [ADDR_W:0] w_rd_ptr_nxt;
    logic            w_pop;
    logic            w_underflow;

    // Pop qualification and next pointer; flush overrides any pop request.
    always_comb begin
        w_fill       = wr_ptr - r_rd_ptr;
        w_pop        = 1'b0;
        w_underflow  = 1'b0;
        w_rd_ptr_nxt = r_rd_ptr;
        if (flush) begin
            w_rd_ptr_nxt = wr_ptr;
        end else if (rd_en) begin
            if (w_fill != PTR_ZERO) begin
                w_pop        = 1'b1;
                w_rd_ptr_nxt = r_rd_ptr + PTR_ONE;
            end else begin
                w_underflow  = 1'b1;
            end
        end else begin
            w_rd_ptr_nxt = r_rd_ptr;
        end
        w_fill_nxt = wr_ptr - w_rd_ptr_nxt;
    end

    // Pointer, read-valid pipeline stage and occupancy flags.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_ptr       <= PTR_ZERO;
            r_rd_valid     <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_empty <= 1'b1;
            r_rd_err       <= 1'b0;
            r_fill_level   <= PTR_ZERO;
        end else begin
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_rd_valid     <= w_pop;
            r_empty        <= (w_fill_nxt == PTR_ZERO);
            r_almost_empty <= (w_fill_nxt <= AE_LVL);
            r_rd_err       <= w_underflow;
            r_fill_level   <= w_fill_nxt;
        end
    end

`ifdef FIFO_RD_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Underflow event counter, held at 255 once reached.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_err_cnt <= 8'd0;
        end else if (w_underflow) begin
            r_err_cnt <= sat_inc8(r_err_cnt);
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    // Memory strobe is combinational so the word lands exactly one cycle after the pop.
    assign mem_rd_en         = w_pop;
    assign mem_rd_addr       = r_rd_ptr[ADDR_W-1:0];
    assign rd_ptr            = r_rd_ptr;
    assign rd_valid          = r_rd_valid;
    assign rd_data           = r_rd_valid ? mem_rd_data : {DATA_W{1'b0}};
    assign fifo_empty        = r_empty;
    assign fifo_almost_empty = r_almost_empty;
    assign fifo_rd_err       = r_rd_err;
    assign fill_level        = r_fill_level;

endmodule
